// File: rtl/bcd_conv_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : bcd_conv_sched                                            |
// | Description: Round-robin scheduler sharing one sequential binary-to-   |
// |              BCD engine among NCH channels. Latches each channel's     |
// |              3-digit result and acknowledges the requester.            |
// | Options    : BCD_SCHED_TIMEOUT_EN builds the WAIT-state watchdog.      |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module bcd_conv_sched #(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      req,
  input  logic [8*NCH-1:0]    bin_in,
  output logic [NCH-1:0]      ack,
  output logic [NCH-1:0]      err,
  output logic [NCH-1:0]      valid,
  output logic [12*NCH-1:0]   bcd_out,
  output logic                conv_start,
  output logic [7:0]          conv_bin,
  input  logic                conv_done,
  input  logic [11:0]         conv_bcd
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_ptr;
  logic [CW-1:0]   r_ch;

  logic            w_any;
  logic [CW-1:0]   w_gidx;
  logic [7:0]      w_gbin;

  // Find the first requesting channel at or above ptr, wrapping at NCH.
  // Scanning from the far end lets the nearest hit overwrite earlier ones.
  always_comb begin
    logic [CW:0] w_idx;
    w_any  = 1'b0;
    w_gidx = '0;
    w_idx  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (CW+1)'(k);
      if (w_idx >= (CW+1)'(NCH)) begin
        w_idx = w_idx - (CW+1)'(NCH);
      end
      if (req[w_idx[CW-1:0]]) begin
        w_any  = 1'b1;
        w_gidx = w_idx[CW-1:0];
      end
    end
  end

  // Select the winning channel's operand from the packed input bus.
  always_comb begin
    w_gbin = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gidx == CW'(i)) begin
        w_gbin = bin_in[i*8 +: 8];
      end
    end
  end

`ifdef BCD_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0]  r_wd_cnt;
  logic            w_wd_expired;

  // Counter holds the number of completed WAIT cycles, so the last
  // permitted WAIT cycle is the one where it reads TIMEOUT-1.
  assign w_wd_expired = (r_wd_cnt == WDW'(TIMEOUT - 1));
`else
  logic            w_unused_timeout;

  assign err              = '0;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  // Scheduler FSM: arbitrate, start the engine, wait, latch and acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_ch       <= '0;
      ack        <= '0;
      valid      <= '0;
      bcd_out    <= '0;
      conv_start <= 1'b0;
      conv_bin   <= '0;
`ifdef BCD_SCHED_TIMEOUT_EN
      err        <= '0;
      r_wd_cnt   <= '0;
`endif
    end else begin
      conv_start <= 1'b0;
      ack        <= '0;
`ifdef BCD_SCHED_TIMEOUT_EN
      err        <= '0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ch       <= w_gidx;
            conv_bin   <= w_gbin;
            conv_start <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
`ifdef BCD_SCHED_TIMEOUT_EN
          r_wd_cnt <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done pulse in the expiry cycle still counts as a good result.
          if (conv_done) begin
            for (int i = 0; i < NCH; i++) begin
              if (r_ch == CW'(i)) begin
                bcd_out[i*12 +: 12] <= conv_bcd;
              end
            end
            valid[r_ch] <= 1'b1;
            ack[r_ch]   <= 1'b1;
            r_state     <= S_ACK;
          end
`ifdef BCD_SCHED_TIMEOUT_EN
          else if (w_wd_expired) begin
            ack[r_ch] <= 1'b1;
            err[r_ch] <= 1'b1;
            r_state   <= S_ACK;
          end else begin
            r_wd_cnt <= r_wd_cnt + WDW'(1);
          end
`endif
        end
        S_ACK: begin
          r_ptr   <= (r_ch == CW'(NCH - 1)) ? '0 : r_ch + CW'(1);
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : tb_bcd_conv_sched                                         |
// | Description: Self-checking bench for bcd_conv_sched with a behavioural |
// |              conversion engine and an ack-driven scoreboard.           |
// | Options    : BCD_SCHED_TIMEOUT_EN adds the watchdog sequence.          |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module tb_bcd_conv_sched;

  localparam int NCH = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NCH-1:0]      req;
  logic [NCH-1:0]      req_main;
  logic [8*NCH-1:0]    bin_in;
  logic [NCH-1:0]      ack;
  logic [NCH-1:0]      err;
  logic [NCH-1:0]      valid;
  logic [12*NCH-1:0]   bcd_out;
  logic                conv_start;
  logic [7:0]          conv_bin;
  logic                conv_done;
  logic [11:0]         conv_bcd;

  logic                eng_done;
  logic [11:0]         eng_bcd;
  logic                man_done;
  logic [11:0]         man_bcd;
  bit                  eng_mute;
  int                  eng_lat;

  int                  n_err = 0;
  int                  n_chk = 0;
  int                  ack_total = 0;
  int                  rel_at = 0;

  typedef struct {
    int          ch;
    logic [11:0] bcd;
    bit          err;
  } exp_t;

  typedef struct {
    int          ch;
    logic [7:0]  val;
    logic [11:0] bcd;
    int          lat;
  } vec_t;

  exp_t                sb[$];
  logic [11:0]         m_bcd[NCH];
  logic [NCH-1:0]      m_valid;

  always #5 clk = ~clk;

  // Requester drops its level once the planned number of acks has arrived.
  assign req       = (ack_total < rel_at) ? req_main : '0;
  assign conv_done = eng_done | man_done;
  assign conv_bcd  = man_done ? man_bcd : eng_bcd;

  bcd_conv_sched #(.NCH(NCH), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .bin_in     (bin_in),
    .ack        (ack),
    .err        (err),
    .valid      (valid),
    .bcd_out    (bcd_out),
    .conv_start (conv_start),
    .conv_bin   (conv_bin),
    .conv_done  (conv_done),
    .conv_bcd   (conv_bcd)
  );

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int x;
    x = int'(v);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Behavioural engine: captures the operand on conv_start and answers
  // eng_lat cycles later unless muted.
  initial begin
    int         cnt;
    logic [7:0] opnd;
    cnt      = 0;
    opnd     = '0;
    eng_done = 1'b0;
    eng_bcd  = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_done = 1'b1;
          eng_bcd  = to_bcd(opnd);
        end
      end else if (conv_start && !eng_mute) begin
        opnd = conv_bin;
        cnt  = eng_lat;
      end
    end
  end

  // Scoreboard: every ack pops the oldest expectation and checks the
  // acknowledged channel, error flag, full result bus and valid mask.
  initial begin
    logic [NCH-1:0]    prev_ack;
    logic [12*NCH-1:0] pk;
    exp_t              e;
    prev_ack = '0;
    m_valid  = '0;
    for (int i = 0; i < NCH; i++) m_bcd[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = '0;
        for (int i = 0; i < NCH; i++) m_bcd[i] = '0;
      end
      if (ack != '0) begin
        chk("ack_single_cycle", 64'(prev_ack), 64'(0));
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_ack: got %b expected none", ack);
        end else begin
          e = sb.pop_front();
          chk("ack_channel", 64'(ack), 64'(1) << e.ch);
          chk("err_flag", 64'(err), e.err ? (64'(1) << e.ch) : 64'(0));
          if (!e.err) begin
            m_bcd[e.ch]   = e.bcd;
            m_valid[e.ch] = 1'b1;
          end
          for (int i = 0; i < NCH; i++) pk[i*12 +: 12] = m_bcd[i];
          chk("bcd_out", 64'(bcd_out), 64'(pk));
          chk("valid", 64'(valid), 64'(m_valid));
        end
        ack_total++;
      end else if (err != '0) begin
        n_chk++;
        n_err++;
        $display("FAIL err_without_ack: got %b expected 0", err);
      end
      prev_ack = ack;
    end
  end

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start(input string nm, input int bound);
    int n;
    n = 0;
    while (!conv_start && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(conv_start), 64'(1));
  endtask

  initial begin
    vec_t        vecs[4];
    logic [11:0] rr_exp[4];
    int          n;
    int          bad;

    vecs[0] = '{2, 8'd237, 12'h237, 5};
    vecs[1] = '{0, 8'd9,   12'h009, 1};
    vecs[2] = '{3, 8'd180, 12'h180, 3};
    vecs[3] = '{1, 8'd64,  12'h064, 2};
    rr_exp[0] = 12'h000;
    rr_exp[1] = 12'h099;
    rr_exp[2] = 12'h100;
    rr_exp[3] = 12'h255;

    rst_n    = 1'b0;
    req_main = 4'b1111;
    rel_at   = 5;
    bin_in   = {8'd255, 8'd100, 8'd99, 8'd0};
    man_done = 1'b0;
    man_bcd  = '0;
    eng_mute = 1'b0;
    eng_lat  = 2;

    // Reset with every channel requesting, then round robin 0,1,2,3,0.
    for (int i = 0; i < 5; i++) sb.push_back('{i % NCH, rr_exp[i % NCH], 1'b0});
    repeat (3) begin
      @(negedge clk);
      chk("reset_ctrl", 64'({ack, err, valid, conv_start, conv_bin}), 64'(0));
      chk("reset_bcd", 64'(bcd_out), 64'(0));
    end
    rst_n = 1'b1;
    wait_start("start_after_reset", 2);
    chk("first_operand", 64'(conv_bin), 64'(8'd0));
    wait_drain(300);

    // Single-channel requests with varied engine latency.
    for (int v = 0; v < 4; v++) begin
      bin_in[vecs[v].ch*8 +: 8] = vecs[v].val;
      eng_lat = vecs[v].lat;
      sb.push_back('{vecs[v].ch, vecs[v].bcd, 1'b0});
      req_main = NCH'(1) << vecs[v].ch;
      rel_at   = ack_total + 1;
      n = 0;
      while (ack == '0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("ack_latency", 64'(n), 64'(vecs[v].lat + 2));
      wait_drain(20);
    end

    // Operand must not follow bin_in once the channel is granted.
    bin_in[15:8] = 8'd42;
    eng_lat  = 6;
    sb.push_back('{1, 12'h042, 1'b0});
    req_main = 4'b0010;
    rel_at   = ack_total + 1;
    wait_start("op_start_seen", 10);
    bin_in[15:8] = 8'd7;
    bad = 0;
    n   = 0;
    while (ack == '0 && n < 20) begin
      @(negedge clk);
      n++;
      if (ack == '0 && conv_bin != 8'd42) bad++;
    end
    chk("operand_stable", 64'(bad), 64'(0));
    chk("op_ack_channel", 64'(ack), 64'(4'b0010));
    wait_drain(10);

    // Reset during WAIT aborts; a stray done afterwards must be ignored.
    eng_mute    = 1'b1;
    bin_in[7:0] = 8'd77;
    req_main    = 4'b0001;
    rel_at      = ack_total + 1;
    wait_start("abort_start_seen", 10);
    repeat (2) @(negedge clk);
    rst_n    = 1'b0;
    req_main = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    man_bcd  = 12'h999;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_ack_after_abort", 64'(ack), 64'(0));
    end
    chk("bcd_after_abort", 64'(bcd_out), 64'(0));
    chk("valid_after_abort", 64'(valid), 64'(0));
    eng_mute = 1'b0;

`ifdef BCD_SCHED_TIMEOUT_EN
    // Channel 0 never completes; channel 1 must be served after the timeout.
    bin_in[7:0]  = 8'd50;
    bin_in[15:8] = 8'd61;
    eng_mute = 1'b1;
    eng_lat  = 2;
    sb.push_back('{0, 12'h000, 1'b1});
    sb.push_back('{1, 12'h061, 1'b0});
    req_main = 4'b0011;
    rel_at   = ack_total + 2;
    wait_start("to_start_seen", 10);
    n = 0;
    while (ack == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", 64'(n), 64'(17));
    chk("timeout_ack_err", 64'({ack, err}), 64'({4'b0001, 4'b0001}));
    eng_mute = 1'b0;
    wait_drain(30);
`endif

    chk("err_quiet_at_end", 64'(err), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/bcd_conv_sched.md
# bcd_conv_sched

Round-robin scheduler that shares one sequential binary-to-BCD conversion engine among NCH requesting channels, such as the temperature and light readouts feeding the display. It arbitrates channel requests, hands the winner's 8-bit value to the engine with a start pulse, waits for the engine's done pulse, and latches the 3-digit BCD result into a per-channel holding register. It then acknowledges the requester. It sits between the sensor-sampling logic and the display driver.

## Interface
- NCH, 4, number of requesting channels; legal 2..8
- TIMEOUT, 64, WAIT-state watchdog limit in cycles; legal 16..1023; used only when the watchdog is compiled in
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req  in  NCH  per-channel conversion request; level, held until that channel's ack
- bin_in  in  8*NCH  packed binary values; channel i at [8i+7:8i]
- ack  out  NCH  one-hot, one-cycle acknowledge for the completed channel
- err  out  NCH  one-cycle pulse alongside ack when the conversion timed out
- valid  out  NCH  sticky; bit i set once channel i has a good result since reset
- bcd_out  out  12*NCH  per-channel result {hundreds,tens,ones}; channel i at [12i+11:12i]
- conv_start  out  1  one-cycle start pulse to the engine
- conv_bin  out  8  operand to the engine; held stable from START through WAIT
- conv_done  in  1  engine completion pulse
- conv_bcd  in  12  engine result; sampled only in the cycle conv_done is high

## Operation
- FSM states: IDLE, START, WAIT, ACK.
- IDLE (arbitrate):
  - If any req bit is set, grant the first set bit scanning upward from ptr, wrapping modulo NCH.
  - Latch the grant index as ch and latch bin_in[ch] into conv_bin, then go to START.
  - If no req bit is set, stay in IDLE.
- START:
  - conv_start is high for exactly this cycle.
  - Go to WAIT unconditionally.
  - conv_done is ignored in this cycle.
- WAIT, on conv_done = 1:
  - bcd_out[ch] <= conv_bcd and valid[ch] <= 1.
  - Go to ACK with the ok flag set.
  - Other channels' bcd_out slices are never disturbed.
- WAIT, on watchdog expiry: see Configuration.
- ACK:
  - ack[ch] = 1; err[ch] = 1 only for a timed-out conversion.
  - ptr <= (ch+1) mod NCH.
  - Go to IDLE.
- Requester rule: drop req on the same edge that ends the ack cycle. The arbiter then sees the request withdrawn in the following IDLE cycle.
- bin_in changes after the grant do not affect the conversion in flight.
- req changes during START/WAIT/ACK are ignored until the next IDLE.
- conv_done arriving in IDLE, START or ACK is ignored, with no state or output change.
- All outputs are registered.

## Timing
- Reset value of every output is 0: ack, err, valid, bcd_out, conv_start, conv_bin.
- Reset also clears ptr, ch and the watchdog counter, and returns the FSM to IDLE.
- Reset asserted mid-conversion aborts it: no ack, no bcd_out update.
  - A later stray conv_done in IDLE is ignored.
- Latency from req sampled high in IDLE:
  - conv_start is high the next cycle.
  - ack is high 1 cycle after the cycle in which conv_done is sampled.
  - Minimum 3 cycles (conv_done on the first WAIT cycle).
- Back-to-back throughput: one conversion per (engine latency + 3) cycles. There is one IDLE cycle between ack and the next conv_start's START cycle.
- Fairness: a continuously requesting channel waits at most NCH-1 other conversions.

## Configuration
- Macro: BCD_SCHED_TIMEOUT_EN. It controls the WAIT-state watchdog.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no conv_done, go to ACK with ack[ch] = 1 and err[ch] = 1.
  - bcd_out[ch] and valid[ch] are unchanged.
  - conv_done in the expiry cycle wins: treated as normal completion, no err.
- Undefined:
  - WAIT holds indefinitely until conv_done.
  - The err port is present but tied to 0, and no counter logic is built.

## Test plan
- Reset: drive rst_n = 0 with req = 4'b1111 -> all outputs 0, no conv_start. Release reset -> first conv_start within 2 cycles with conv_bin = bin_in[0].
- Single request: req[2] = 1, bin_in[2] = 8'd237, engine returns 12'h237 after 5 cycles -> bcd_out[2] = 12'h237, valid = 4'b0100, ack = 4'b0100 for exactly 1 cycle.
- Round-robin: req = 4'b1111 held, channel values 0/99/100/255 -> grants in order 0,1,2,3,0. Results are 12'h000, 12'h099, 12'h100, 12'h255.
- Operand stability: change bin_in[1] from 8'd42 to 8'd7 one cycle after the grant -> conv_bin stays 8'd42 through WAIT and bcd_out[1] = 12'h042.
- Timeout (macro defined, TIMEOUT = 16): never return conv_done -> ack[0] and err[0] high together on the cycle after the 16th WAIT cycle. bcd_out[0] and valid[0] are unchanged, and the next channel is granted after that.
- Reset mid-WAIT: assert rst_n = 0 during WAIT, release it, then pulse conv_done in IDLE -> no ack and all bcd_out remain 0.
